// File: rtl/idu_pkg.sv
// Shared decode definitions for the IDU decode queue: RV32I/Zicsr opcodes,
// ALU operation codes, instruction classes and the decoded record layout.
package idu_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011, OPC_FENCE  = 7'b0001111,
                          OPC_OP_IMM = 7'b0010011, OPC_AUIPC  = 7'b0010111,
                          OPC_STORE  = 7'b0100011, OPC_OP     = 7'b0110011,
                          OPC_LUI    = 7'b0110111, OPC_BRANCH = 7'b1100011,
                          OPC_JALR   = 7'b1100111, OPC_JAL    = 7'b1101111,
                          OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073,
                           INST_EBREAK = 32'h0010_0073,
                           INST_MRET   = 32'h3020_0073;

   localparam logic [5:0]
      ALU_ADDI  = 6'b000000, ALU_LUI   = 6'b000001, ALU_AUIPC  = 6'b000010,
      ALU_JAL   = 6'b000011, ALU_JALR  = 6'b000100, ALU_ADD    = 6'b000101,
      ALU_BEQ   = 6'b000110, ALU_BNE   = 6'b000111, ALU_LW     = 6'b001000,
      ALU_SW    = 6'b001001, ALU_FENCE = 6'b001010, ALU_EBREAK = 6'b001011,
      ALU_SUB   = 6'b001100, ALU_SLL   = 6'b001101, ALU_SLT    = 6'b001110,
      ALU_UNIMP = 6'b001111, ALU_ZEXT_B = 6'b001111,
      ALU_BLT   = 6'b010000, ALU_BGE   = 6'b010001, ALU_BLTU   = 6'b010010,
      ALU_BGEU  = 6'b010011, ALU_LB    = 6'b010100, ALU_LH     = 6'b010101,
      ALU_LBU   = 6'b010110, ALU_LHU   = 6'b010111, ALU_SB     = 6'b011000,
      ALU_SH    = 6'b011001, ALU_SLTI  = 6'b011010, ALU_SLTIU  = 6'b011011,
      ALU_XORI  = 6'b011100, ALU_ORI   = 6'b011101, ALU_ANDI   = 6'b011110,
      ALU_SLLI  = 6'b011111, ALU_SRLI  = 6'b100000, ALU_SRAI   = 6'b100001,
      ALU_SLTU  = 6'b100010, ALU_XOR   = 6'b100011, ALU_SRL    = 6'b100100,
      ALU_SRA   = 6'b100101, ALU_OR    = 6'b100110, ALU_AND    = 6'b100111,
      ALU_CSRRW = 6'b110000, ALU_CSRRS = 6'b110001, ALU_ECALL  = 6'b110010,
      ALU_MRET  = 6'b110011, ALU_CSRRC = 6'b110100, ALU_CSRRWI = 6'b110101,
      ALU_CSRRSI = 6'b110110, ALU_CSRRCI = 6'b110111;

   // Class value doubles as the index of its performance counter.
   typedef enum logic [2:0] {COMPUTE, LOAD, STORE, BRANCH, JUMP, CSR, OTHER} inst_class_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [5:0]  alu_op;
      logic [31:0] imm;
      logic [11:0] csr_addr;
      logic        csr_wen;
      logic        is_ecall;
      logic        is_mret;
      logic        illegal;
      inst_class_t cls;
   } decoded_t;

endpackage

// File: rtl/idu_decoder.sv
// Combinational RV32I/Zicsr decoder: one instruction word in, one decoded record out.
module idu_decoder import idu_pkg::*; (
   input  logic [31:0] i_inst,
   output decoded_t    o_dec
);

   logic [6:0]  w_opc, w_f7;
   logic [2:0]  w_f3;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
   logic [5:0]  w_alu;
   logic        w_legal;
   inst_class_t w_cls;

   assign w_opc   = i_inst[6:0];
   assign w_f3    = i_inst[14:12];
   assign w_f7    = i_inst[31:25];
   assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
   assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
   assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
   assign w_imm_u = {i_inst[31:12], 12'b0};
   assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

   always_comb begin
      // NOTE: every signal gets a default first, so no path through the cases can infer a latch.
      w_alu   = ALU_UNIMP;
      w_cls   = OTHER;
      w_imm   = '0;
      w_legal = 1'b1;
      case (w_opc)
         OPC_LUI:   begin w_alu = ALU_LUI;   w_cls = COMPUTE; w_imm = w_imm_u; end
         OPC_AUIPC: begin w_alu = ALU_AUIPC; w_cls = COMPUTE; w_imm = w_imm_u; end
         OPC_JAL:   begin w_alu = ALU_JAL;   w_cls = JUMP;    w_imm = w_imm_j; end
         OPC_JALR:  begin w_alu = ALU_JALR;  w_cls = JUMP;    w_imm = w_imm_i; w_legal = (w_f3 == 3'b000); end
         OPC_FENCE: begin w_alu = ALU_FENCE; w_imm = w_imm_i; w_legal = (w_f3 == 3'b000); end
         OPC_BRANCH: begin
            w_cls = BRANCH; w_imm = w_imm_b;
            case (w_f3)
               3'b000:  w_alu = ALU_BEQ;
               3'b001:  w_alu = ALU_BNE;
               3'b100:  w_alu = ALU_BLT;
               3'b101:  w_alu = ALU_BGE;
               3'b110:  w_alu = ALU_BLTU;
               3'b111:  w_alu = ALU_BGEU;
               default: w_legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            w_cls = LOAD; w_imm = w_imm_i;
            case (w_f3)
               3'b000:  w_alu = ALU_LB;
               3'b001:  w_alu = ALU_LH;
               3'b010:  w_alu = ALU_LW;
               3'b100:  w_alu = ALU_LBU;
               3'b101:  w_alu = ALU_LHU;
               default: w_legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            w_cls = STORE; w_imm = w_imm_s;
            case (w_f3)
               3'b000:  w_alu = ALU_SB;
               3'b001:  w_alu = ALU_SH;
               3'b010:  w_alu = ALU_SW;
               default: w_legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            w_cls = COMPUTE; w_imm = w_imm_i;
            case (w_f3)
               3'b000: w_alu = ALU_ADDI;
               3'b010: w_alu = ALU_SLTI;
               3'b011: w_alu = ALU_SLTIU;
               3'b100: w_alu = ALU_XORI;
               3'b110: w_alu = ALU_ORI;
               // andi rd, rs, 0xff is reported as ZEXT.B
               3'b111: w_alu = (i_inst[31:20] == 12'h0FF) ? ALU_ZEXT_B : ALU_ANDI;
               3'b001: begin w_alu = ALU_SLLI; w_legal = (w_f7 == F7_BASE); end
               default: begin
                  w_alu   = w_f7[5] ? ALU_SRAI : ALU_SRLI;
                  w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
               end
            endcase
         end
         OPC_OP: begin
            w_cls = COMPUTE;
            if (w_f7 == F7_BASE) begin
               case (w_f3)
                  3'b000:  w_alu = ALU_ADD;
                  3'b001:  w_alu = ALU_SLL;
                  3'b010:  w_alu = ALU_SLT;
                  3'b011:  w_alu = ALU_SLTU;
                  3'b100:  w_alu = ALU_XOR;
                  3'b101:  w_alu = ALU_SRL;
                  3'b110:  w_alu = ALU_OR;
                  default: w_alu = ALU_AND;
               endcase
            end else if (w_f7 == F7_ALT && w_f3 == 3'b000) w_alu = ALU_SUB;
            else if (w_f7 == F7_ALT && w_f3 == 3'b101)     w_alu = ALU_SRA;
            else                                           w_legal = 1'b0;
         end
         OPC_SYSTEM: begin
            case (w_f3)
               3'b000: begin
                  if      (i_inst == INST_ECALL)  w_alu = ALU_ECALL;
                  else if (i_inst == INST_EBREAK) w_alu = ALU_EBREAK;
                  else if (i_inst == INST_MRET)   w_alu = ALU_MRET;
                  else                            w_legal = 1'b0;
               end
               3'b001:  begin w_alu = ALU_CSRRW;  w_cls = CSR; end
               3'b010:  begin w_alu = ALU_CSRRS;  w_cls = CSR; end
               3'b011:  begin w_alu = ALU_CSRRC;  w_cls = CSR; end
               3'b101:  begin w_alu = ALU_CSRRWI; w_cls = CSR; end
               3'b110:  begin w_alu = ALU_CSRRSI; w_cls = CSR; end
               3'b111:  begin w_alu = ALU_CSRRCI; w_cls = CSR; end
               default: w_legal = 1'b0;
            endcase
         end
         default: w_legal = 1'b0;
      endcase
   end

   always_comb begin
      o_dec          = '0;
      o_dec.opcode   = w_opc;
      o_dec.func3    = w_f3;
      o_dec.func7    = w_f7;
      o_dec.rs1      = (i_inst == INST_ECALL) ? 5'd17 : i_inst[19:15];
      o_dec.rs2      = i_inst[24:20];
      o_dec.rd       = i_inst[11:7];
      o_dec.alu_op   = w_legal ? w_alu : ALU_UNIMP;
      o_dec.imm      = w_legal ? w_imm : '0;
      o_dec.cls      = w_legal ? w_cls : OTHER;
      o_dec.csr_wen  = w_legal && (w_cls == CSR);
      o_dec.csr_addr = (w_legal && (w_cls == CSR)) ? i_inst[31:20] : '0;
      o_dec.is_ecall = (i_inst == INST_ECALL);
      o_dec.is_mret  = (i_inst == INST_MRET);
      o_dec.illegal  = !w_legal;
   end

endmodule

// File: rtl/idu_decode_queue.sv
// Decode stage: decodes on IFU accept, buffers DEPTH records in order, issues to EXU.
// Define IDU_PERF_EN to build the saturating per-class performance counters.
module idu_decode_queue import idu_pkg::*; #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   ifu_valid,
   output logic                   ifu_ready,
   input  logic [31:0]            inst,
   input  logic [XLEN-1:0]        ifu_to_idu_pc,
   output logic                   exu_valid,
   input  logic                   exu_ready,
   output logic [XLEN-1:0]        idu_to_exu_pc,
   output logic [6:0]             opcode,
   output logic [2:0]             func3,
   output logic [6:0]             func7,
   output logic [4:0]             rs1,
   output logic [4:0]             rs2,
   output logic [4:0]             rd,
   output logic [5:0]             alu_op,
   output logic [XLEN-1:0]        imm,
   output logic [11:0]            csr_addr,
   output logic                   csr_wen,
   output logic                   is_ecall,
   output logic                   is_mret,
   output logic                   illegal,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [8*CNT_W-1:0]     perf_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   decoded_t         r_entry [DEPTH];
   logic [XLEN-1:0]  r_pc    [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [OCC_W-1:0] r_count;
   decoded_t         w_dec, w_head;
   logic             w_enq, w_deq;

   idu_decoder u_decoder (.i_inst(inst), .o_dec(w_dec));

   assign ifu_ready = (r_count != OCC_W'(DEPTH)) && !flush && !reset;
   assign exu_valid = (r_count != '0) && !flush;
   assign w_enq     = ifu_valid && ifu_ready;
   assign w_deq     = exu_valid && exu_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         // NOTE: storage is cleared too, so the head outputs read zero straight out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= '0;
            r_pc[i]    <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_entry[r_wr_ptr] <= w_dec;
            r_pc[r_wr_ptr]    <= ifu_to_idu_pc;
            r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
         end
         if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + OCC_W'(w_enq) - OCC_W'(w_deq);
      end
   end

   assign w_head        = r_entry[r_rd_ptr];
   assign idu_to_exu_pc = r_pc[r_rd_ptr];
   assign opcode        = w_head.opcode;
   assign func3         = w_head.func3;
   assign func7         = w_head.func7;
   assign rs1           = w_head.rs1;
   assign rs2           = w_head.rs2;
   assign rd            = w_head.rd;
   assign alu_op        = w_head.alu_op;
   assign imm           = XLEN'($signed(w_head.imm));
   assign csr_addr      = w_head.csr_addr;
   assign csr_wen       = w_head.csr_wen;
   assign is_ecall      = w_head.is_ecall;
   assign is_mret       = w_head.is_mret;
   assign illegal       = w_head.illegal;
   assign occupancy     = r_count;

`ifdef IDU_PERF_EN
   localparam int SUM_W = CNT_W + OCC_W;

   logic [CNT_W-1:0] r_perf [8];
   logic [SUM_W-1:0] w_flush_sum;

   // Slot 7 counts flushed entries; slots 0..6 are indexed by instruction class.
   assign w_flush_sum = SUM_W'(r_perf[7]) + SUM_W'(r_count);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) r_perf[i] <= '0;
      end else begin
         if (flush)
            r_perf[7] <= (w_flush_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : w_flush_sum[CNT_W-1:0];
         if (w_deq && (r_perf[w_head.cls] != '1))
            r_perf[w_head.cls] <= r_perf[w_head.cls] + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_perf
      assign perf_cnt[g*CNT_W +: CNT_W] = r_perf[g];
   end
`else
   logic w_unused_perf;

   assign perf_cnt      = '0;
   assign w_unused_perf = ^{w_head.cls, w_deq};
`endif

endmodule

// File: tb/tb_idu_decode_queue.sv
// Randomised self-checking bench for idu_decode_queue against a queue-based reference model.
// Instructions are built by encoding chosen fields, so expected immediates are known up front.
module tb_idu_decode_queue;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int SAT   = 15;

   logic              clock = 1'b0;
   logic              reset, flush, ifu_valid, exu_ready;
   logic              ifu_ready, exu_valid;
   logic [31:0]       inst;
   logic [XLEN-1:0]   ifu_to_idu_pc, idu_to_exu_pc, imm;
   logic [6:0]        opcode, func7;
   logic [2:0]        func3;
   logic [4:0]        rs1, rs2, rd;
   logic [5:0]        alu_op;
   logic [11:0]       csr_addr;
   logic              csr_wen, is_ecall, is_mret, illegal;
   logic [1:0]        occupancy;
   logic [8*CNT_W-1:0] perf_cnt;

   typedef enum {F_R, F_I, F_S, F_B, F_U, F_J} fmt_e;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [5:0]  alu;
      logic [31:0] imm;
      int          cls;
      bit          illegal;
      bit          csr_wen;
      bit          ecall;
      bit          mret;
      logic [11:0] csr;
   } exp_t;

   exp_t q[$];
   int   m_perf[8];
   int   total = 0;
   int   bad   = 0;
   exp_t idle_e;

   idu_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .inst(inst), .ifu_to_idu_pc(ifu_to_idu_pc),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .idu_to_exu_pc(idu_to_exu_pc),
      .opcode(opcode), .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd),
      .alu_op(alu_op), .imm(imm), .csr_addr(csr_addr), .csr_wen(csr_wen),
      .is_ecall(is_ecall), .is_mret(is_mret), .illegal(illegal),
      .occupancy(occupancy), .perf_cnt(perf_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > SAT) ? SAT : x;
   endfunction

   // Class numbering: 0 compute, 1 load, 2 store, 3 branch, 4 jump, 5 csr, 6 other, 7 flushed.
   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] w, input logic [5:0] alu,
                               input logic [31:0] imm_v, input int cls, input bit ill);
      exp_t e;
      e.pc      = pc;
      e.inst    = w;
      e.alu     = alu;
      e.imm     = imm_v;
      e.cls     = cls;
      e.illegal = ill;
      e.ecall   = (w == 32'h0000_0073);
      e.mret    = (w == 32'h3020_0073);
      e.csr_wen = (cls == 5);
      e.csr     = (cls == 5) ? w[31:20] : 12'h0;
      return e;
   endfunction

   function automatic exp_t rand_inst(input logic [31:0] pc);
      logic [31:0] r, imm_v, w;
      logic [4:0]  rdv, r1, r2;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [5:0]  alu;
      fmt_e        fmt;
      int          cls;
      r   = $urandom;
      rdv = 5'($urandom_range(0, 31));
      r1  = 5'($urandom_range(0, 31));
      r2  = 5'($urandom_range(0, 31));
      f3  = 3'b000;
      f7  = 7'b0000000;
      cls = 0;
      case ($urandom_range(0, 10))
         0:  begin opc = 7'b0010011; fmt = F_I; alu = 6'b000000; end
         1:  begin opc = 7'b0110111; fmt = F_U; alu = 6'b000001; end
         2:  begin opc = 7'b0010111; fmt = F_U; alu = 6'b000010; end
         3:  begin opc = 7'b1101111; fmt = F_J; alu = 6'b000011; cls = 4; end
         4:  begin opc = 7'b1100111; fmt = F_I; alu = 6'b000100; cls = 4; end
         5:  begin opc = 7'b0110011; fmt = F_R; alu = 6'b000101; end
         6:  begin opc = 7'b1100011; fmt = F_B; alu = 6'b000110; cls = 3; end
         7:  begin opc = 7'b1100011; fmt = F_B; alu = 6'b000111; cls = 3; f3 = 3'b001; end
         8:  begin opc = 7'b0000011; fmt = F_I; alu = 6'b001000; cls = 1; f3 = 3'b010; end
         9:  begin opc = 7'b0100011; fmt = F_S; alu = 6'b001001; cls = 2; f3 = 3'b010; end
         default: begin opc = 7'b0110011; fmt = F_R; alu = 6'b001100; f7 = 7'b0100000; end
      endcase
      case (fmt)
         F_I: begin imm_v = {{20{r[11]}}, r[11:0]}; w = {r[11:0], r1, f3, rdv, opc}; end
         F_S: begin imm_v = {{20{r[11]}}, r[11:0]}; w = {r[11:5], r2, r1, f3, r[4:0], opc}; end
         F_B: begin imm_v = {{19{r[12]}}, r[12:1], 1'b0};
                    w = {r[12], r[10:5], r2, r1, f3, r[4:1], r[11], opc}; end
         F_U: begin imm_v = {r[31:12], 12'h000}; w = {r[31:12], rdv, opc}; end
         F_J: begin imm_v = {{11{r[20]}}, r[20:1], 1'b0};
                    w = {r[20], r[10:1], r[11], r[19:12], rdv, opc}; end
         default: begin imm_v = 32'h0; w = {f7, r2, r1, f3, rdv, opc}; end
      endcase
      return mk(pc, w, alu, imm_v, cls, 1'b0);
   endfunction

   task automatic check_head(input exp_t e);
      check("pc",       idu_to_exu_pc, e.pc);
      check("opcode",   opcode, e.inst[6:0]);
      check("func3",    func3, e.inst[14:12]);
      check("func7",    func7, e.inst[31:25]);
      check("rs1",      rs1, e.ecall ? 5'd17 : e.inst[19:15]);
      check("rs2",      rs2, e.inst[24:20]);
      check("rd",       rd, e.inst[11:7]);
      check("alu_op",   alu_op, e.alu);
      check("imm",      imm, e.imm);
      check("csr_addr", csr_addr, e.csr);
      check("flags",    {illegal, csr_wen, is_ecall, is_mret}, {e.illegal, e.csr_wen, e.ecall, e.mret});
   endtask

   task automatic check_perf();
      logic [31:0] want;
      want = '0;
`ifdef IDU_PERF_EN
      for (int i = 0; i < 8; i++) want[i*CNT_W +: CNT_W] = 4'(m_perf[i]);
`endif
      check("perf_cnt", perf_cnt, want);
   endtask

   // One clock: drive after the falling edge, compare, then advance the model at the rising edge.
   task automatic cycle(input bit v, input exp_t e, input bit rdy, input bit fl);
      bit exp_rdy, exp_vld, enq, deq;
      @(negedge clock);
      ifu_valid     = v;
      inst          = e.inst;
      ifu_to_idu_pc = e.pc;
      exu_ready     = rdy;
      flush         = fl;
      #1;
      exp_rdy = (q.size() != DEPTH) && !fl;
      exp_vld = (q.size() != 0) && !fl;
      check("ifu_ready", ifu_ready, exp_rdy);
      check("exu_valid", exu_valid, exp_vld);
      check("occupancy", occupancy, 64'(q.size()));
      if (q.size() != 0) check_head(q[0]);
      check_perf();
      enq = v && exp_rdy;
      deq = exp_vld && rdy;
      @(posedge clock);
      if (fl) begin
         m_perf[7] = sat(m_perf[7] + q.size());
         q.delete();
      end else begin
         if (deq) begin
            m_perf[q[0].cls] = sat(m_perf[q[0].cls] + 1);
            void'(q.pop_front());
         end
         if (enq) q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      flush     = 1'b0;
      ifu_valid = 1'b0;
      exu_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      #1;
      check("rst_ifu_ready", ifu_ready, 1'b0);
      check("rst_exu_valid", exu_valid, 1'b0);
      check("rst_occupancy", occupancy, 2'd0);
      check("rst_alu_op",    alu_op, 6'd0);
      check("rst_imm",       imm, 32'd0);
      check("rst_csr_addr",  csr_addr, 12'd0);
      check("rst_illegal",   illegal, 1'b0);
      check("rst_pc",        idu_to_exu_pc, 32'd0);
      check("rst_perf",      perf_cnt, 32'd0);
      q.delete();
      for (int i = 0; i < 8; i++) m_perf[i] = 0;
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] pc;
      reset = 1'b1; flush = 1'b0; ifu_valid = 1'b0; exu_ready = 1'b0;
      inst = '0; ifu_to_idu_pc = '0;
      idle_e = mk(32'h0, 32'h0, 6'd0, 32'h0, 0, 1'b0);
      do_reset();

      // addi x1, x0, 5 appears at the head one cycle after acceptance
      cycle(1'b1, mk(32'h8000_0000, 32'h0050_0093, 6'b000000, 32'd5, 0, 1'b0), 1'b1, 1'b0);
      cycle(1'b0, idle_e, 1'b1, 1'b0);

      // back-pressure: three offers, only two fit
      for (int i = 0; i < 3; i++) cycle(1'b1, rand_inst(32'h0000_1000 + 32'(i * 4)), 1'b0, 1'b0);
      cycle(1'b0, idle_e, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, idle_e, 1'b1, 1'b0);

      // flush a full queue while IFU offers
      for (int i = 0; i < 2; i++) cycle(1'b1, rand_inst(32'h0000_2000 + 32'(i * 4)), 1'b0, 1'b0);
      cycle(1'b1, rand_inst(32'h0000_2008), 1'b0, 1'b1);
      cycle(1'b0, idle_e, 1'b1, 1'b0);

      // system, illegal and ZEXT.B encodings
      cycle(1'b1, mk(32'h3000, 32'h0000_0073, 6'b110010, 32'h0,  6, 1'b0), 1'b1, 1'b0);
      cycle(1'b1, mk(32'h3004, 32'h3020_0073, 6'b110011, 32'h0,  6, 1'b0), 1'b1, 1'b0);
      cycle(1'b1, mk(32'h3008, 32'h3412_9073, 6'b110000, 32'h0,  5, 1'b0), 1'b1, 1'b0);
      cycle(1'b1, mk(32'h300C, 32'h0010_0073, 6'b001011, 32'h0,  6, 1'b0), 1'b1, 1'b0);
      cycle(1'b1, mk(32'h3010, 32'hFFFF_FFFF, 6'b001111, 32'h0,  6, 1'b1), 1'b1, 1'b0);
      cycle(1'b1, mk(32'h3014, 32'h0FF0_F093, 6'b001111, 32'hFF, 0, 1'b0), 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b0, idle_e, 1'b1, 1'b0);

      // random traffic with occasional flushes
      pc = 32'h0001_0000;
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, rand_inst(pc), $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
         pc += 32'd4;
      end

      // reset in the middle of traffic behaves like power-on
      for (int i = 0; i < 2; i++) cycle(1'b1, rand_inst(32'h0002_0000 + 32'(i * 4)), 1'b0, 1'b0);
      do_reset();

      // twenty issued ADDIs drive the compute counter into saturation
      for (int i = 0; i < 20; i++)
         cycle(1'b1, mk(32'h0003_0000 + 32'(i * 4), 32'h0050_0093, 6'b000000, 32'd5, 0, 1'b0),
               1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b0, idle_e, 1'b1, 1'b0);
      #1;
`ifdef IDU_PERF_EN
      check("compute_sat", perf_cnt[3:0], 4'hF);
`else
      check("perf_off", perf_cnt, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/idu_decode_queue.md
Name: idu_decode_queue

Overview:
- Parametrised next-generation decode stage between IFU and EXU.
- Decodes each RV32 instruction when it is accepted from IFU and stores the decoded record, with its PC, in a DEPTH-entry circular queue. Records are issued in order to EXU over a valid/ready handshake.
- Adds what the single-slot decoder lacks: multi-entry buffering, pipeline flush, an illegal-instruction flag and saturating per-class performance counters.

Parameters:
- DEPTH, 2, queue entries; power of two, >= 2.
- XLEN, 32, PC/immediate width.
- CNT_W, 32, performance counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all queued entries (redirect)
- ifu_valid  in  1  IFU has an instruction
- ifu_ready  out  1  queue can accept
- inst  in  32  instruction word
- ifu_to_idu_pc  in  XLEN  instruction PC
- exu_valid  out  1  head entry valid
- exu_ready  in  1  EXU accepts head
- idu_to_exu_pc  out  XLEN  head PC
- opcode/func3/func7  out  7/3/7  head instruction fields
- rs1/rs2/rd  out  5/5/5  register indices; rs1 forced to 17 for ECALL
- alu_op  out  6  operation code
- imm  out  XLEN  sign-extended immediate
- csr_addr  out  12  CSR address
- csr_wen/is_ecall/is_mret  out  1/1/1  system-instruction flags
- illegal  out  1  head opcode/funct combination not implemented
- occupancy  out  $clog2(DEPTH)+1  entries held
- perf_cnt  out  8*CNT_W  counters {flushed, other, csr, jump, branch, store, load, compute}, compute in the LSBs

Behaviour:
- Reset: queue empty, pointers 0, occupancy 0, exu_valid 0, every stored entry zeroed. All decoded outputs read 0 (alu_op 0, imm 0, csr_addr 0), illegal 0, perf counters 0.
- ifu_ready = (occupancy != DEPTH) && !flush && !reset.
- exu_valid = (occupancy != 0) && !flush.
- Enqueue on ifu_valid && ifu_ready; dequeue on exu_valid && exu_ready.
- Latency: an instruction accepted in cycle N is presented at the head no earlier than cycle N+1. There is no combinational inst-to-EXU path. Head outputs come straight from storage.
- Simultaneous enqueue and dequeue: occupancy unchanged, both pointers advance. Full with a dequeue: ifu_ready stays 0 that cycle; there is no fall-through.
- Pointers wrap modulo DEPTH.
- Outputs remain stable while exu_valid && !exu_ready.
- Flush:
  - Next cycle: occupancy 0, pointers reset, exu_valid 0.
  - Any IFU offer in the flush cycle is not accepted.
  - The flushed counter adds the occupancy at flush time.
- Reset mid-operation: identical to power-on reset.
- Decode encodings:
  - ADDI 000000, LUI 000001, AUIPC 000010, JAL 000011, JALR 000100, ADD 000101.
  - BEQ 000110, BNE 000111, LW 001000, SW 001001, EBREAK 001011, SUB 001100.
  - CSRRW 110000, CSRRS 110001, ECALL 110010, MRET 110011.
  - UNIMP 001111.
  - All remaining codes: full RV32I/Zicsr table in the package.
- illegal = 1 when decode falls to UNIMP. ZEXT.B shares code 001111 but sets illegal 0.
- Immediates by format:
  - I and JALR: sext inst[31:20].
  - S: {31:25, 11:7}.
  - B: {31, 7, 30:25, 11:8, 0}.
  - U: {31:12, 12'b0}.
  - J: {31, 19:12, 20, 30:21, 0}.
  - System and R-type: 0.
- Class counters increment on the dequeue handshake by head opcode and saturate at all-ones.
- Counters are unaffected by flush, apart from the flushed counter.

Optional Feature:
- IDU_PERF_EN defined: perf_cnt counters are implemented as described.
- Not defined: perf_cnt tied to 0 and no counter flops are synthesised.
- Queue and decode behaviour is identical in both builds.

Decomposition:
- Package idu_pkg holds:
  - opcode localparams and alu_op localparams, including ALU_UNIMP.
  - inst_class enum: COMPUTE, LOAD, STORE, BRANCH, JUMP, CSR, OTHER.
  - Packed struct decoded_t: fields, alu_op, imm, csr_addr, flags, illegal, class.
- One sub-module, idu_decoder: purely combinational, maps inst to decoded_t. idu_decode_queue instantiates it on the enqueue path.

Test Plan:
- Reset, then inst 0x00500093 (addi x1,x0,5) @pc 0x80000000 with exu_ready=1 -> one cycle later exu_valid=1, alu_op=000000, imm=5, rd=1, pc 0x80000000.
- exu_ready=0, DEPTH=2, three back-to-back offers -> two accepted; ifu_ready=0 while occupancy=2; release -> in-order issue, PCs preserved.
- Queue holding 2 entries, flush=1 with ifu_valid=1 -> next cycle occupancy=0, exu_valid=0, the offered inst is dropped, flushed counter +2.
- Insts 0x00000073, 0x30200073, 0x34129073 -> ECALL: is_ecall=1, rs1=17. MRET: is_mret=1. CSRRW: csr_wen=1, csr_addr=0x341.
- Inst 0xFFFFFFFF -> illegal=1, alu_op=001111. Inst 0x0FF0F093 (ZEXT.B) -> alu_op=001111, illegal=0.
- With IDU_PERF_EN and CNT_W=4: 20 issued ADDIs -> compute counter saturates at 15. Without the macro -> perf_cnt=0.
